// File: rtl/async_fifo_pkg.sv
// Shared definitions for the async FIFO read-side blocks.
//   burst_rd_state_e : burst reader FSM states
//   SKID_DEPTH       : number of entries in the output skid buffer
package async_fifo_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } burst_rd_state_e;

    localparam int unsigned SKID_DEPTH = 2;

endpackage

// File: rtl/async_fifo_skid_buffer.sv
// Two-entry in-order skid buffer between the FIFO pop side and the output stream.
// Ports:
//   clk, reset : clock and asynchronous active-high reset
//   wr_en      : write strobe (caller guarantees count < SKID_DEPTH)
//   wr_data    : word to store
//   count      : current occupancy (0..SKID_DEPTH)
//   rd_valid   : buffer holds at least one word
//   rd_data    : head word
//   rd_ready   : consumer accepts the head word when rd_valid is high
module async_fifo_skid_buffer
    import async_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic [1:0]            count,
    output logic                  rd_valid,
    output logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  rd_ready
);

    logic [DATA_WIDTH-1:0] mem_q [SKID_DEPTH];
    logic                  wr_ptr_q;
    logic                  rd_ptr_q;
    logic [1:0]            count_q;
    logic                  rd_en;

    assign rd_valid = (count_q != 2'd0);
    assign rd_data  = mem_q[rd_ptr_q];
    assign count    = count_q;
    assign rd_en    = rd_valid && rd_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SKID_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (wr_en) begin
                mem_q[wr_ptr_q] <= wr_data;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (rd_en) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            // Simultaneous write and read leave occupancy unchanged.
            unique case ({wr_en, rd_en})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/async_fifo_burst_reader.sv
// Read-side burst consumer for an FWFT async FIFO.
// A start command with burst_len pops exactly that many words and streams them out
// on a valid/ready interface, with m_last on the final word.
// Ports:
//   clk, reset             : read-domain clock, asynchronous active-high reset
//   fifo_empty, fifo_data  : FWFT FIFO head interface
//   fifo_pop               : pop strobe to the FIFO
//   start, burst_len       : burst request (ignored unless idle)
//   busy, done             : burst in progress / one-cycle completion pulse
//   m_valid, m_data,
//   m_last, m_ready        : output stream
module async_fifo_burst_reader
    import async_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned LEN_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_pop,
    input  logic                  start,
    input  logic [LEN_WIDTH-1:0]  burst_len,
    output logic                  busy,
    output logic                  done,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    input  logic                  m_ready
);

    burst_rd_state_e      state_q, state_d;
    logic [LEN_WIDTH-1:0] pop_rem_q, pop_rem_d;
    logic [LEN_WIDTH-1:0] out_rem_q, out_rem_d;
    logic                 done_q, done_d;
    logic [1:0]           skid_count;
    logic                 handshake;

    // Pop depends only on registered state and fifo_empty, never on m_ready.
    assign fifo_pop  = (state_q == RUN) && !fifo_empty && (pop_rem_q != '0) &&
                       (skid_count < 2'(SKID_DEPTH));
    assign handshake = m_valid && m_ready;
    assign m_last    = m_valid && (out_rem_q == LEN_WIDTH'(1));
    assign busy      = (state_q != IDLE);
    assign done      = done_q;

    always_comb begin
        state_d   = state_q;
        pop_rem_d = pop_rem_q;
        out_rem_d = out_rem_q;
        done_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (burst_len != '0) begin
                        state_d   = RUN;
                        pop_rem_d = burst_len;
                        out_rem_d = burst_len;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            RUN, DRAIN: begin
                if (fifo_pop) begin
                    pop_rem_d = pop_rem_q - LEN_WIDTH'(1);
                end
                if (handshake) begin
                    out_rem_d = out_rem_q - LEN_WIDTH'(1);
                end
                // Final handshake wins, which also covers skipping DRAIN from RUN.
                if (handshake && (out_rem_q == LEN_WIDTH'(1))) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else if ((state_q == RUN) && (pop_rem_d == '0)) begin
                    state_d = DRAIN;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            pop_rem_q <= '0;
            out_rem_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pop_rem_q <= pop_rem_d;
            out_rem_q <= out_rem_d;
            done_q    <= done_d;
        end
    end

    async_fifo_skid_buffer #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_skid (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (fifo_pop),
        .wr_data  (fifo_data),
        .count    (skid_count),
        .rd_valid (m_valid),
        .rd_data  (m_data),
        .rd_ready (m_ready)
    );

endmodule

// File: doc/async_fifo_burst_reader.md
Name: async_fifo_burst_reader

Overview:
Read-side consumer for the async FIFO. It runs in the read clock domain and drains the FIFO's first-word-fall-through pop/empty interface. A start command with a length drives a burst of exactly that many words out on a valid/ready stream, with last marking the final word. A 2-entry skid buffer decouples fifo_pop from downstream m_ready and keeps throughput at 1 word/cycle.

Parameters:
DATA_WIDTH, 32, width of FIFO data and m_data
LEN_WIDTH, 8, width of burst_len; max burst is 2^LEN_WIDTH-1 words

Ports:
clk  input  1  read-domain clock
reset  input  1  asynchronous, active-high reset
fifo_empty  input  1  FIFO empty flag, synchronous to clk
fifo_data  input  DATA_WIDTH  FIFO head word, valid whenever fifo_empty=0 (FWFT)
fifo_pop  output  1  pop strobe to the FIFO
start  input  1  one-cycle burst request
burst_len  input  LEN_WIDTH  words in the burst, sampled when start is accepted
busy  output  1  high from accepted start until the final output handshake
done  output  1  one-cycle pulse after a burst completes
m_valid  output  1  stream data valid
m_data  output  DATA_WIDTH  stream data
m_last  output  1  final word of the burst, qualified by m_valid
m_ready  input  1  downstream ready

Behaviour:
- Reset, asynchronous: state=IDLE; fifo_pop, busy, done, m_valid, m_last are 0; m_data=0; skid count=0; both counters are 0.
- State IDLE:
  - start=1 with burst_len!=0: latch pop_rem=out_rem=burst_len and go to RUN. busy=1 from the next cycle.
  - start=1 with burst_len=0: done=1 next cycle, stay in IDLE, busy stays 0.
- start is ignored when not in IDLE, with no queuing.
- State RUN:
  - fifo_pop = !fifo_empty && (pop_rem!=0) && (skid count<2).
  - fifo_pop is combinational from registered state and fifo_empty only. It never depends on m_ready.
  - On pop, fifo_data is written into the skid buffer in the same cycle and pop_rem decrements.
  - When pop_rem reaches 0, go to DRAIN.
- State DRAIN: fifo_pop=0. Wait until the handshake with out_rem==1 completes, then go to IDLE, pulse done for 1 cycle, and drop busy.
- RUN to IDLE directly: if the final pop and the final handshake happen in the same cycle, skip DRAIN.
- Skid buffer (2 entries, in-order):
  - m_valid=(count!=0); m_data=head entry.
  - Handshake = m_valid && m_ready. Each handshake decrements out_rem.
  - m_last = m_valid && (out_rem==1).
  - A pop and a handshake in the same cycle leave count unchanged, giving 1 word/cycle sustained.
- Latency: a word popped at cycle N appears on m_data at N+1 when the buffer was empty.
- Backpressure: while m_valid && !m_ready, m_data and m_last hold stable. At most 2 words are popped ahead of consumption.
- FIFO empty mid-burst: no pop, and m_valid drops once the buffer drains. The burst resumes when fifo_empty falls. There is no timeout.
- Underflow: fifo_pop is never asserted while fifo_empty=1.
- Reset mid-burst: words already popped but not yet delivered are discarded. The FIFO pointers are not restored.
- Counter widths are LEN_WIDTH. No wrap-around can occur because the counters only decrement from the latched length down to 0.

Decomposition:
- Shared package async_fifo_pkg:
  - typedef enum logic [1:0] {IDLE, RUN, DRAIN} burst_rd_state_e
  - SKID_DEPTH=2 constant
- Sub-module async_fifo_skid_buffer, parameterised by DATA_WIDTH:
  - Ports: clk, reset, wr_en, wr_data, count, rd_valid, rd_data, rd_ready.
  - Holds the storage and occupancy. The FSM and counters stay in the top.

Test Plan:
- FIFO preloaded with 0xA0..0xA3, start with burst_len=4, m_ready=1 → pops on 4 consecutive cycles; m_data=0xA0..0xA3 on consecutive cycles starting 1 cycle after the first pop; m_last only with 0xA3; done pulses once; busy deasserts with done.
- burst_len=0 → done the next cycle, busy never rises, fifo_pop stays 0.
- burst_len=3 with m_ready held low after start → exactly 2 pops, then m_data holds the first word stable. Release m_ready → remaining pop occurs; all 3 words in order; m_last on the 3rd.
- burst_len=5 with the FIFO going empty after 2 words for 4 cycles → fifo_pop never high while empty; stream pauses, then completes 5 words; done once.
- Reset asserted mid-burst after 2 of 6 words → all outputs 0 immediately (async). After release: IDLE, and a new start with burst_len=1 works normally.
- start pulsed again while busy → ignored; only the first burst's words appear and done pulses once.
